// File: rtl/universal_shift_ctrl.sv
// Universal shift register: shift/rotate/load/clear, multi-bit shifts run one bit per clock.
// Latency: single-cycle ops finish on the accept edge (done next cycle); N-bit shifts take N en-edges.
// Backpressure: start is accepted only when busy=0 and en=1; en=0 freezes all state.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              global enable (0 holds FSM, counter, out and carry)
//   start           command strobe; mode/amount latched and pdata sampled on accept
//   mode            000 NOP, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 ASR, 110 LOAD, 111 CLEAR
//   amount          shift distance, saturated to size
//   d               serial fill bit, sampled on every shift step
//   pdata           parallel load value
//   out, carry      register contents and last bit shifted/rotated out
//   busy, done      busy while shifting; done is a one-cycle completion pulse (held while en=0)
module universal_shift_ctrl #(
  parameter int size  = 16,
  parameter int CNT_W = $clog2(size + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             d,
  input  logic [size-1:0]  pdata,
  output logic [size-1:0]  out,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ROL   = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ASR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(size);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       op_q;

  logic             is_shift_op;
  logic [CNT_W-1:0] sat_amount;
  logic [size-1:0]  step_out;
  logic             step_carry;

  assign is_shift_op = (mode >= OP_SHL) && (mode <= OP_ASR);
  assign sat_amount  = (amount > SIZE_C) ? SIZE_C : amount;

  // One bit-step of the latched shift command; carry takes the bit leaving the register.
  always_comb begin
    step_out   = out;
    step_carry = carry;
    case (op_q)
      OP_SHL: begin
        step_out   = {out[size-2:0], d};
        step_carry = out[size-1];
      end
      OP_SHR: begin
        step_out   = {d, out[size-1:1]};
        step_carry = out[0];
      end
      OP_ROL: begin
        step_out   = {out[size-2:0], out[size-1]};
        step_carry = out[size-1];
      end
      OP_ROR: begin
        step_out   = {out[0], out[size-1:1]};
        step_carry = out[0];
      end
      OP_ASR: begin
        step_out   = {out[size-1], out[size-1:1]};
        step_carry = out[0];
      end
      default: begin
        step_out   = out;
        step_carry = carry;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      op_q  <= OP_NOP;
      out   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q <= mode;
            if (is_shift_op && (amount != '0)) begin
              // Accept edge only arms the counter; the first step happens on the next en edge.
              count <= sat_amount;
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              // NOP, LOAD, CLEAR and zero-distance shifts complete on the accept edge.
              // A zero-distance shift moves nothing, so out and carry are left alone.
              case (mode)
                OP_LOAD:  out <= pdata;
                OP_CLEAR: begin
                  out   <= '0;
                  carry <= 1'b0;
                end
                default: ;
              endcase
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately not looked at here: commands are not queued.
          out   <= step_out;
          carry <= step_carry;
          count <= count - ONE_C;
          if (count == ONE_C) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_ctrl.sv
// Self-checking bench for universal_shift_ctrl: directed scenarios then random commands.
// Inputs are driven and outputs sampled on the falling edge.
// The reference model computes whole multi-bit shifts with arithmetic on 32-bit values.
module tb_universal_shift_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [2:0]    mode;
  logic [4:0]    amount;
  logic          d;
  logic [W-1:0]  pdata;
  logic [W-1:0]  out;
  logic          carry;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  // Reference state and per-command bookkeeping.
  logic [31:0] m_out;
  logic        m_carry;
  int          cyc;
  int          bcnt;
  int          exp_lat;
  int          exp_busy;

  universal_shift_ctrl #(.size(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .d      (d),
    .pdata  (pdata),
    .out    (out),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected effect of a whole command, computed from the mode rules directly.
  task automatic model(input logic [2:0] md, input int amt, input logic dv, input logic [15:0] pd);
    int k;
    logic [31:0] v;
    logic [31:0] mask;
    logic signed [31:0] sv;
    k = (amt > W) ? W : amt;
    v = m_out;
    mask = 32'h0000_FFFF;
    exp_lat = 1;
    exp_busy = 0;
    if (md == 3'd6) begin
      m_out = {16'h0, pd};
    end else if (md == 3'd7) begin
      m_out = 32'h0;
      m_carry = 1'b0;
    end else if (md != 3'd0 && k > 0) begin
      exp_lat = k + 1;
      exp_busy = k;
      case (md)
        3'd1: begin
          m_out = ((v << k) | (dv ? ((32'h1 << k) - 32'h1) : 32'h0)) & mask;
          m_carry = v[W-k];
        end
        3'd2: begin
          m_out = (v >> k) | (dv ? (mask & ~(mask >> k)) : 32'h0);
          m_carry = v[k-1];
        end
        3'd3: begin
          m_out = ((v << k) | (v >> (W - k))) & mask;
          m_carry = v[W-k];
        end
        3'd4: begin
          m_out = ((v >> k) | (v << (W - k))) & mask;
          m_carry = v[k-1];
        end
        default: begin
          sv = {{16{v[15]}}, v[15:0]};
          m_out = 32'($signed(sv) >>> k) & mask;
          m_carry = v[k-1];
        end
      endcase
    end
  endtask

  // Advance one cycle, counting busy cycles of the current command.
  task automatic step();
    if (busy === 1'b1) bcnt++;
    @(negedge clk);
    cyc++;
  endtask

  // Present a command for one edge and update the model; returns in cycle 1 after accept.
  task automatic issue(input logic [2:0] md, input int amt, input logic dv, input logic [15:0] pd);
    start = 1'b1;
    mode = md;
    amount = 5'(amt);
    d = dv;
    pdata = pd;
    model(md, amt, dv, pd);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
  endtask

  // Wait (bounded) for done, then check latency, busy length, result and pulse width.
  task automatic finish_cmd(input string tag, input int lat, input int nb, input bit btb);
    while (done !== 1'b1 && cyc < 200) step();
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_busycyc"}, 32'(bcnt), 32'(nb));
    chk({tag, "_out"}, 32'(out), m_out);
    chk({tag, "_carry"}, 32'(carry), 32'(m_carry));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'h0);
    if (!btb) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'h0);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] md, input int amt, input logic dv,
                     input logic [15:0] pd, input bit btb);
    issue(md, amt, dv, pd);
    finish_cmd(tag, exp_lat, exp_busy, btb);
  endtask

  initial begin
    logic [15:0] hold;
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 3'd0; amount = 5'd0; d = 1'b0; pdata = 16'h0;
    m_out = 32'h0; m_carry = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // start while en=0 must be ignored.
    en = 1'b0; start = 1'b1; mode = 3'd6; pdata = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk("en0_start_out", 32'(out), 32'h0);
    chk("en0_start_done", 32'(done), 32'h0);
    start = 1'b0; en = 1'b1;
    @(negedge clk);

    // 1: LOAD
    run("t1_load", 3'd6, 0, 1'b0, 16'hA5F0, 1'b0);
    chk("t1_val", 32'(out), 32'hA5F0);
    // 2: SHL 4 with d=1
    run("t2_shl4", 3'd1, 4, 1'b1, 16'h0, 1'b0);
    chk("t2_val", 32'(out), 32'h5F0F);
    // 3: ASR and SHR by 3
    run("t3_load", 3'd6, 0, 1'b0, 16'h8000, 1'b0);
    run("t3_asr3", 3'd5, 3, 1'b1, 16'h0, 1'b0);
    chk("t3_asr_val", 32'(out), 32'hF000);
    run("t3_load2", 3'd6, 0, 1'b0, 16'h8000, 1'b0);
    run("t3_shr3", 3'd2, 3, 1'b0, 16'h0, 1'b0);
    chk("t3_shr_val", 32'(out), 32'h1000);
    // 4: ROR by 20 saturates to a full rotation
    run("t4_load", 3'd6, 0, 1'b0, 16'hA5F0, 1'b0);
    run("t4_ror20", 3'd4, 20, 1'b0, 16'h0, 1'b0);
    chk("t4_val", 32'(out), 32'hA5F0);

    // 5: SHL 8 with an ignored start and a 3-cycle en pause.
    issue(3'd1, 8, 1'b1, 16'h0);
    step();
    start = 1'b1; mode = 3'd6; pdata = 16'hFFFF;
    step();
    start = 1'b0; en = 1'b0;
    hold = out;
    repeat (3) begin
      step();
      chk("t5_pause_out", 32'(out), 32'(hold));
      chk("t5_pause_busy", 32'(busy), 32'h1);
    end
    en = 1'b1;
    finish_cmd("t5_shl8", 12, 11, 1'b1);
    // done is held while en=0, then clears on the next en edge.
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 32'h1);
    end
    en = 1'b1;
    @(negedge clk);
    chk("hold_done_clear", 32'(done), 32'h0);

    // 6: async reset in the middle of a shift.
    run("t6_load", 3'd6, 0, 1'b0, 16'h1234, 1'b0);
    issue(3'd1, 8, 1'b1, 16'h0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t6_rst_out", 32'(out), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_out = 32'h0; m_carry = 1'b0;
    @(negedge clk);
    run("t6_after_load", 3'd6, 0, 1'b0, 16'hC3A1, 1'b0);
    run("t6_after_rol", 3'd3, 5, 1'b0, 16'h0, 1'b0);

    // Random commands, some issued back-to-back from the done cycle.
    for (int i = 0; i < 60; i++) begin
      run($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 16'($urandom), (i != 59) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
